// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared FSM state encoding and job-size legality check for conv_job_sequencer.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_READ      = 3'd3,
        ST_PRESENT   = 3'd4
    } state_e;

    typedef struct packed {
        logic        legal;
        logic [31:0] n;
    } job_chk_t;

    // N = size_y + size_h - 1; legal when size_y >= 1 and N fits the MEM_Z address space.
    function automatic job_chk_t job_check(input int unsigned size_y, input int unsigned size_h,
                                           input int unsigned awz);
        job_chk_t r;
        r.n     = size_y + size_h - 32'd1;
        r.legal = (size_y != 0) && (r.n <= (32'd1 << awz));
        return r;
    endfunction

endpackage

// File: rtl/conv_seq_watchdog.sv
// conv_seq_watchdog: counts enabled cycles and flags expiry after LIMIT of them; clear wins.
module conv_seq_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clear_i ? '0 : (en_i && !expired_o) ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign expired_o = cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: job intake, core start/done handshake and MEM_Z result streaming.
// Optional WAIT_DONE watchdog enabled by defining CONV_SEQ_TIMEOUT_EN.
module conv_job_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH   = 5,
    parameter int unsigned ADDRESS_WIDTH_Z = 6,
    parameter int unsigned DATA_WIDTH_OUT  = 16,
    parameter int unsigned SIZE_H          = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid_i,
    output logic                       job_ready_o,
    input  logic [ADDRESS_WIDTH-1:0]   job_size_y_i,
    output logic                       conv_start_o,
    output logic [ADDRESS_WIDTH-1:0]   conv_size_y_o,
    input  logic                       conv_done_i,
    output logic [ADDRESS_WIDTH_Z-1:0] memz_rd_addr_o,
    input  logic [DATA_WIDTH_OUT-1:0]  memz_rd_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_WIDTH_OUT-1:0]  out_data_o,
    output logic                       out_last_o,
    output logic                       busy_o,
    output logic                       err_o
);
    state_e                       state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]     size_q, size_d;
    logic [ADDRESS_WIDTH_Z-1:0]   last_q, last_d;
    logic [ADDRESS_WIDTH_Z-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH_OUT-1:0]    data_q, data_d;
    logic                         err_q, err_d;
    logic                         timeout;
    job_chk_t                     chk;

    assign chk = job_check(32'(job_size_y_i), SIZE_H, ADDRESS_WIDTH_Z);

`ifdef CONV_SEQ_TIMEOUT_EN
    conv_seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q != ST_WAIT_DONE),
        .en_i     (state_q == ST_WAIT_DONE),
        .expired_o(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE:
                if (job_valid_i) begin
                    if (chk.legal) begin
                        state_d = ST_START;
                        size_d  = job_size_y_i;
                        last_d  = ADDRESS_WIDTH_Z'(chk.n - 32'd1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            ST_START: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE:
                if (conv_done_i) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            ST_READ: begin
                state_d = ST_PRESENT;
                data_d  = memz_rd_data_i;
            end
            ST_PRESENT:
                if (out_ready_i) begin
                    if (addr_q == last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= ST_IDLE;
            size_q  <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end

    // The next address goes out so the registered memory has the word ready by the end of READ.
    assign memz_rd_addr_o = addr_d;
    assign job_ready_o    = state_q == ST_IDLE;
    assign busy_o         = state_q != ST_IDLE;
    assign conv_start_o   = state_q == ST_START;
    assign conv_size_y_o  = size_q;
    assign out_valid_o    = state_q == ST_PRESENT;
    assign out_last_o     = (state_q == ST_PRESENT) && (addr_q == last_q);
    assign out_data_o     = data_q;
    assign err_o          = err_q;
endmodule

// File: tb/tb_conv_job_sequencer.sv
// tb_conv_job_sequencer: directed jobs against a stream-level scoreboard of conv_job_sequencer.
// Defining CONV_SEQ_TIMEOUT_EN switches the no-done scenario to the watchdog expectation.
module tb_conv_job_sequencer;
    localparam int AW = 6, AWZ = 6, DW = 16, SH = 4, TO = 16;

    logic           clk = 0, rst = 1;
    logic           job_valid_i = 0, conv_done_i = 0, out_ready_i = 1;
    logic [AW-1:0]  job_size_y_i = '0;
    logic           job_ready_o, conv_start_o, out_valid_o, out_last_o, busy_o, err_o;
    logic [AW-1:0]  conv_size_y_o;
    logic [AWZ-1:0] memz_rd_addr_o;
    logic [DW-1:0]  memz_rd_data_i = '0, out_data_o;
    logic [DW-1:0]  mem [64];

    int checks = 0, errors = 0;
    int exp_size = 0, exp_n = 0, k = 0, words = 0, starts = 0, errs_seen = 0;
    bit hs_prev = 0, err_prev = 0;

    conv_job_sequencer #(
        .ADDRESS_WIDTH(AW), .ADDRESS_WIDTH_Z(AWZ), .DATA_WIDTH_OUT(DW),
        .SIZE_H(SH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_size_y_i(job_size_y_i), .conv_start_o(conv_start_o), .conv_size_y_o(conv_size_y_o),
        .conv_done_i(conv_done_i), .memz_rd_addr_o(memz_rd_addr_o), .memz_rd_data_i(memz_rd_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 64; i++) mem[i] = DW'(10 * (i + 1));

    // MEM_Z model: one-cycle registered read.
    always @(posedge clk) memz_rd_data_i <= mem[memz_rd_addr_o];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every start carries the job size, words arrive in address order with last on N-1.
    always @(negedge clk) begin
        if (rst) begin
            k = 0;
            hs_prev = 0;
            err_prev = 0;
        end else begin
            if (conv_start_o) begin
                starts++;
                chk("start_size", conv_size_y_o, exp_size);
                k = 0;
            end
            chk("busy_vs_ready", busy_o, !job_ready_o);
            if (err_o) begin
                errs_seen++;
                chk("err_width", err_prev, 0);
            end
            if (out_valid_o) begin
                chk("word_data", out_data_o, mem[k]);
                chk("word_last", out_last_o, k == exp_n - 1);
                chk("word_rate", hs_prev, 0);
                if (!out_ready_i) chk("stall_addr", memz_rd_addr_o, k);
                else begin
                    words++;
                    k++;
                end
            end else if (out_last_o) chk("last_without_valid", out_last_o, 0);
            hs_prev = out_valid_o && out_ready_i;
            err_prev = err_o;
        end
    end

    task automatic send_job(input int sz, input bit done_in_start);
        @(negedge clk);
        chk("ready_before_job", job_ready_o, 1);
        @(posedge clk); #1;
        job_size_y_i = AW'(sz);
        job_valid_i = 1;
        @(posedge clk); #1;
        job_valid_i = 0;
        if (done_in_start) begin
            conv_done_i = 1;
            @(posedge clk); #1;
            conv_done_i = 0;
        end
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        conv_done_i = 1;
        @(posedge clk); #1;
        conv_done_i = 0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_o && n < bound);
        chk("idle_within_bound", n < bound, 1);
    endtask

    task automatic wait_word(input int val, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid_o && out_data_o == DW'(val)) && n < bound);
        chk("word_seen", n < bound, 1);
    endtask

    task automatic legal_job(input int sz);
        exp_size = sz;
        exp_n = sz + SH - 1;
        words = 0;
    endtask

    initial begin
        int s0, e0, n;
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, e0, n;
        @(negedge clk);
        chk("rst_job_ready", job_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_start", conv_start_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_last", out_last_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_size", conv_size_y_o, 0);
        chk("rst_addr", memz_rd_addr_o, 0);
        @(negedge clk);
        rst = 0;

        // Nominal size-2 job: 5 words 10..50.
        legal_job(2);
        s0 = starts;
        send_job(2, 0);
        @(negedge clk);
        chk("nom_start_pulse", conv_start_o, 1);
        chk("nom_size", conv_size_y_o, 2);
        chk("nom_ready_low", job_ready_o, 0);
        pulse_done();
        @(negedge clk);
        chk("nom_read_no_valid", out_valid_o, 0);
        @(negedge clk);
        chk("nom_first_valid", out_valid_o, 1);
        chk("nom_first_data", out_data_o, 10);
        wait_idle(40);
        chk("nom_words", words, 5);
        chk("nom_starts", starts, s0 + 1);
        chk("nom_busy_after", busy_o, 0);

        // Backpressure on word 2 for 3 cycles.
        legal_job(2);
        send_job(2, 0);
        pulse_done();
        wait_word(20, 20);
        @(posedge clk); #1;
        out_ready_i = 0;
        wait_word(30, 10);
        repeat (2) begin
            @(negedge clk);
            chk("bp_valid_held", out_valid_o, 1);
            chk("bp_data_held", out_data_o, 30);
            chk("bp_addr_held", memz_rd_addr_o, 2);
        end
        @(posedge clk); #1;
        out_ready_i = 1;
        wait_idle(40);
        chk("bp_words", words, 5);

        // Illegal sizes 0 and 62 (N=65), then legal 31 (N=34).
        s0 = starts;
        e0 = errs_seen;
        send_job(0, 0);
        @(negedge clk);
        chk("ill0_err", err_o, 1);
        chk("ill0_no_start", conv_start_o, 0);
        chk("ill0_ready", job_ready_o, 1);
        @(negedge clk);
        chk("ill0_err_done", err_o, 0);
        send_job(62, 0);
        @(negedge clk);
        chk("ill62_err", err_o, 1);
        chk("ill62_busy", busy_o, 0);
        @(negedge clk);
        chk("ill_err_count", errs_seen, e0 + 2);
        chk("ill_no_starts", starts, s0);
        legal_job(31);
        send_job(31, 0);
        pulse_done();
        wait_idle(200);
        chk("big_words", words, 34);
        chk("big_no_err", errs_seen, e0 + 2);

        // Done in IDLE and in the START cycle is ignored.
        pulse_done();
        @(negedge clk);
        chk("done_idle_busy", busy_o, 0);
        legal_job(2);
        send_job(2, 1);
        repeat (6) begin
            @(negedge clk);
            chk("done_ign_busy", busy_o, 1);
            chk("done_ign_valid", out_valid_o, 0);
        end
        pulse_done();
        wait_idle(40);
        chk("done_ord_words", words, 5);

        // Asynchronous reset after word 2 is accepted.
        legal_job(2);
        send_job(2, 0);
        pulse_done();
        wait_word(30, 20);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("mrst_valid", out_valid_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_ready", job_ready_o, 1);
        chk("mrst_data", out_data_o, 0);
        chk("mrst_addr", memz_rd_addr_o, 0);
        chk("mrst_size", conv_size_y_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("mrst_ready_after", job_ready_o, 1);
        legal_job(2);
        send_job(2, 0);
        pulse_done();
        wait_idle(40);
        chk("mrst_rerun_words", words, 5);

        // No done ever.
        legal_job(2);
        e0 = errs_seen;
        send_job(2, 0);
`ifdef CONV_SEQ_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_o && n < 60);
        chk("to_err_cycle", n, TO + 2);
        chk("to_idle", busy_o, 0);
        repeat (3) @(negedge clk);
        chk("to_no_words", words, 0);
        chk("to_err_count", errs_seen, e0 + 1);
`else
        repeat (40) @(negedge clk);
        chk("nowd_still_busy", busy_o, 1);
        chk("nowd_no_err", errs_seen, e0);
        chk("nowd_no_words", words, 0);
        pulse_done();
        wait_idle(40);
        chk("nowd_words", words, 5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
